// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port block RAM: access sizes, load
// extension encoding and the default start of the I/O address window.
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_e;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

    // Matches funct3[2] of the load instruction.
    localparam logic LOAD_SIGNED   = 1'b0;
    localparam logic LOAD_UNSIGNED = 1'b1;

endpackage

// File: rtl/mem_load_format.sv
// Load-data formatter: right-justifies the addressed byte/half/word of a raw
// memory word and sign- or zero-extends it to 32 bits.
module mem_load_format
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        data = shifted;
        case (size)
            BYTE: begin
                if (sign == LOAD_UNSIGNED) data = {24'b0, shifted[7:0]};
                else                       data = {{24{shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                if (sign == LOAD_UNSIGNED) data = {16'b0, shifted[15:0]};
                else                       data = {{16{shifted[15]}}, shifted[15:0]};
            end
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/bram_dual_port.sv
// Dual-port 32-bit block RAM: port 1 is a word-only instruction fetch, port 2
// is a byte/half/word load-store port with an I/O window above IO_BASE.
module bram_dual_port
    import mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter string       INIT_FILE  = "otter_memory.mem",
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic        MEM_CLK,
    input  logic        MEM_RST,
    input  logic [31:0] MEM_ADDR1,
    input  logic        MEM_READ1,
    output logic [31:0] MEM_DOUT1,
    input  logic [31:0] MEM_ADDR2,
    input  logic [31:0] MEM_DIN2,
    input  logic        MEM_WRITE2,
    input  logic        MEM_READ2,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_SIGN,
    output logic [31:0] MEM_DOUT2,
    input  logic [31:0] IO_IN,
    output logic        IO_WR,
    output logic        ERR
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx1;
    logic [ADDR_WIDTH-1:0] idx2;
    logic                  unused_addr1_hi;

    // Fetches outside the array are not flagged; they read the truncated index.
    assign idx1            = MEM_ADDR1[ADDR_WIDTH+1:2];
    assign idx2            = MEM_ADDR2[ADDR_WIDTH+1:2];
    assign unused_addr1_hi = ^MEM_ADDR1[31:ADDR_WIDTH+2];

    // ------------------------------------------------------------------
    // Address decode and error detection
    // ------------------------------------------------------------------
    logic is_io2;
    logic ram_hit2;
    logic err1;
    logic err2;
    logic misalign2;

    assign is_io2   = (MEM_ADDR2 >= IO_BASE);
    assign ram_hit2 = !is_io2 && ((MEM_ADDR2 >> (ADDR_WIDTH + 2)) == 32'd0);

    always_comb begin
        misalign2 = 1'b0;
        case (MEM_SIZE)
            BYTE:    misalign2 = 1'b0;
            HALF:    misalign2 = MEM_ADDR2[0];
            WORD:    misalign2 = (MEM_ADDR2[1:0] != 2'b00);
            default: misalign2 = 1'b1;
        endcase
    end

    assign err1 = MEM_READ1 && (MEM_ADDR1[1:0] != 2'b00);
    assign err2 = (MEM_READ2 || MEM_WRITE2) && (misalign2 || (!is_io2 && !ram_hit2));
    assign ERR  = err1 || err2;

    assign IO_WR = MEM_WRITE2 && is_io2 && !ERR;

    // ------------------------------------------------------------------
    // Port-2 byte-lane write
    // ------------------------------------------------------------------
    logic [3:0]  be2;
    logic [31:0] wdata2;
    logic        wr_en2;

    always_comb begin
        be2    = 4'b0000;
        wdata2 = MEM_DIN2;
        case (MEM_SIZE)
            BYTE: begin
                be2    = 4'b0001 << MEM_ADDR2[1:0];
                wdata2 = {4{MEM_DIN2[7:0]}};
            end
            HALF: begin
                be2    = MEM_ADDR2[1] ? 4'b1100 : 4'b0011;
                wdata2 = {2{MEM_DIN2[15:0]}};
            end
            WORD:    be2 = 4'b1111;
            default: be2 = 4'b0000;
        endcase
    end

    assign wr_en2 = MEM_WRITE2 && ram_hit2 && !err2;

    always_ff @(posedge MEM_CLK) begin
        if (wr_en2) begin
            for (int b = 0; b < 4; b++) begin
                if (be2[b]) mem[idx2][b*8 +: 8] <= wdata2[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read registers (read-first: they sample the array before the write lands)
    // ------------------------------------------------------------------
    always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
        if (MEM_RST) begin
            MEM_DOUT1 <= 32'd0;
        end else if (MEM_READ1) begin
            MEM_DOUT1 <= mem[idx1];
        end
    end

    logic [31:0] rd_word;
    logic [1:0]  rd_off;
    logic [1:0]  rd_size;
    logic        rd_sign;
    logic        rd_io;

    always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
        if (MEM_RST) begin
            rd_word <= 32'd0;
            rd_off  <= 2'd0;
            rd_size <= 2'd0;
            rd_sign <= 1'b0;
            rd_io   <= 1'b0;
        end else if (MEM_READ2) begin
            rd_word <= is_io2 ? IO_IN : mem[idx2];
            rd_off  <= MEM_ADDR2[1:0];
            rd_size <= MEM_SIZE;
            rd_sign <= MEM_SIGN;
            rd_io   <= is_io2;
        end
    end

    logic [31:0] fmt_data;

    mem_load_format u_fmt (
        .word   (rd_word),
        .offset (rd_off),
        .size   (rd_size),
        .sign   (rd_sign),
        .data   (fmt_data)
    );

    // I/O reads bypass formatting and return the full bus word.
    assign MEM_DOUT2 = rd_io ? rd_word : fmt_data;

endmodule

// File: tb/tb_bram_dual_port.sv
// Self-checking bench for bram_dual_port: directed scenarios plus randomized
// load/store/fetch traffic checked against a byte-addressed reference model.
module tb_bram_dual_port;

    logic        clk;
    logic        rst;
    logic [31:0] addr1;
    logic        read1;
    logic [31:0] dout1;
    logic [31:0] addr2;
    logic [31:0] din2;
    logic        write2;
    logic        read2;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] dout2;
    logic [31:0] io_in;
    logic        io_wr;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [int unsigned];

    bram_dual_port #(
        .ADDR_WIDTH (14),
        .INIT_FILE  (""),
        .IO_BASE    (32'h1100_0000)
    ) dut (
        .MEM_CLK    (clk),
        .MEM_RST    (rst),
        .MEM_ADDR1  (addr1),
        .MEM_READ1  (read1),
        .MEM_DOUT1  (dout1),
        .MEM_ADDR2  (addr2),
        .MEM_DIN2   (din2),
        .MEM_WRITE2 (write2),
        .MEM_READ2  (read2),
        .MEM_SIZE   (size),
        .MEM_SIGN   (sign),
        .MEM_DOUT2  (dout2),
        .IO_IN      (io_in),
        .IO_WR      (io_wr),
        .ERR        (err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int unsigned idx;
        logic [31:0] w;
        idx = int'(a[15:2]);
        w = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
        if (sz == 2'd0)      w[a[1:0]*8 +: 8]   = d[7:0];
        else if (sz == 2'd1) w[a[1]*16 +: 16]   = d[15:0];
        else                 w                  = d;
        model_mem[idx] = w;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int unsigned idx;
        idx = int'(a[15:2]);
        return model_mem.exists(idx) ? model_mem[idx] : 32'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        v = model_word(a) >> (8 * a[1:0]);
        if (sz == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (!sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (!sg && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        read1  = 1'b0;
        write2 = 1'b0;
        read2  = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        addr2 = a; din2 = d; size = sz; write2 = 1'b1;
        @(posedge clk);
        #1 clear_inputs();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg, output logic [31:0] d);
        @(negedge clk);
        addr2 = a; size = sz; sign = sg; read2 = 1'b1;
        @(posedge clk);
        #1 clear_inputs();
        d = dout2;
    endtask

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr1 = a; read1 = 1'b1;
        @(posedge clk);
        #1 clear_inputs();
        d = dout1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_checks++;
        if (dout1 !== 32'd0) begin n_fail++; $display("FAIL reset_dout1: got %h expected %h", dout1, 32'd0); end
        n_checks++;
        if (dout2 !== 32'd0) begin n_fail++; $display("FAIL reset_dout2: got %h expected %h", dout2, 32'd0); end
        n_checks++;
        if (err !== 1'b0 || io_wr !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got err=%b io_wr=%b expected 0 0", err, io_wr); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_write_fetch();
        logic [31:0] d;
        do_store(32'h100, 32'hDEADBEEF, 2'd2);
        model_store(32'h100, 32'hDEADBEEF, 2'd2);
        do_fetch(32'h100, d);
        n_checks++;
        if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_fetch: got %h expected %h", d, 32'hDEADBEEF); end
    endtask

    task automatic test_subword_loads();
        logic [31:0] d;
        logic [31:0] a_tab [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [1:0]  s_tab [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        g_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] e_tab [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        do_store(32'h100, 32'h80FF7F01, 2'd2);
        model_store(32'h100, 32'h80FF7F01, 2'd2);
        for (int i = 0; i < 4; i++) begin
            do_load(a_tab[i], s_tab[i], g_tab[i], d);
            n_checks++;
            if (d !== e_tab[i]) begin n_fail++; $display("FAIL subword_load_%0d: got %h expected %h", i, d, e_tab[i]); end
        end
    endtask

    task automatic test_subword_stores();
        logic [31:0] d;
        do_store(32'h200, 32'h0, 2'd2);
        do_store(32'h201, 32'hFFFF_FFAB, 2'd0);
        do_load(32'h200, 2'd2, 1'b0, d);
        n_checks++;
        if (d !== 32'h0000AB00) begin n_fail++; $display("FAIL store_byte: got %h expected %h", d, 32'h0000AB00); end
        do_store(32'h202, 32'h5555_1234, 2'd1);
        do_load(32'h200, 2'd2, 1'b0, d);
        n_checks++;
        if (d !== 32'h1234AB00) begin n_fail++; $display("FAIL store_half: got %h expected %h", d, 32'h1234AB00); end
        model_store(32'h200, 32'h1234AB00, 2'd2);
    endtask

    task automatic test_io();
        logic [31:0] d;
        do_store(32'h0, 32'h5A5A5A5A, 2'd2);
        model_store(32'h0, 32'h5A5A5A5A, 2'd2);
        @(negedge clk);
        addr2 = 32'h1100_0000; din2 = 32'h77777777; size = 2'd2; write2 = 1'b1;
        #1;
        n_checks++;
        if (io_wr !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL io_write_strobe: got io_wr=%b err=%b expected 1 0", io_wr, err); end
        @(posedge clk);
        #1 clear_inputs();
        #1;
        n_checks++;
        if (io_wr !== 1'b0) begin n_fail++; $display("FAIL io_write_idle: got %b expected 0", io_wr); end
        io_in = 32'hCAFEF00D;
        do_load(32'h1100_0004, 2'd2, 1'b0, d);
        n_checks++;
        if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL io_read_word: got %h expected %h", d, 32'hCAFEF00D); end
        io_in = 32'h8123_4567;
        do_load(32'h1100_0005, 2'd0, 1'b0, d);
        n_checks++;
        if (d !== 32'h8123_4567) begin n_fail++; $display("FAIL io_read_unformatted: got %h expected %h", d, 32'h8123_4567); end
        do_fetch(32'h0, d);
        n_checks++;
        if (d !== model_word(32'h0)) begin n_fail++; $display("FAIL io_array_untouched: got %h expected %h", d, model_word(32'h0)); end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [31:0] a_tab [6] = '{32'h102, 32'h101, 32'h100, 32'h0001_0000, 32'h1100_0002, 32'h100};
        logic [1:0]  s_tab [6] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2};
        logic        w_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        e_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            addr2 = a_tab[i]; size = s_tab[i]; din2 = 32'hFFFF_FFFF;
            write2 = w_tab[i]; read2 = !w_tab[i];
            #1;
            n_checks++;
            if (err !== e_tab[i] || io_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL err_case_%0d: got err=%b io_wr=%b expected err=%b io_wr=0", i, err, io_wr, e_tab[i]);
            end
            @(posedge clk);
            #1 clear_inputs();
        end
        do_load(32'h100, 2'd2, 1'b0, d);
        n_checks++;
        if (d !== model_word(32'h100)) begin n_fail++; $display("FAIL err_store_suppressed: got %h expected %h", d, model_word(32'h100)); end
        @(negedge clk);
        addr1 = 32'h6; read1 = 1'b1;
        #1;
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_fetch_misaligned: got %b expected 1", err); end
        @(posedge clk);
        #1 clear_inputs();
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        do_fetch(32'h100, d);
        do_load(32'h200, 2'd2, 1'b0, d);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (dout1 !== 32'd0 || dout2 !== 32'd0) begin n_fail++; $display("FAIL reset_async: got dout1=%h dout2=%h expected 0 0", dout1, dout2); end
        @(negedge clk);
        rst = 1'b0;
        do_fetch(32'h100, d);
        n_checks++;
        if (d !== model_word(32'h100)) begin n_fail++; $display("FAIL reset_retains_array: got %h expected %h", d, model_word(32'h100)); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        do_store(32'h300, 32'h1111_1111, 2'd2);
        model_store(32'h300, 32'h1111_1111, 2'd2);
        @(negedge clk);
        addr1 = 32'h300; read1 = 1'b1;
        addr2 = 32'h300; din2 = 32'h2222_2222; size = 2'd2; sign = 1'b0;
        write2 = 1'b1; read2 = 1'b1;
        @(posedge clk);
        #1 clear_inputs();
        n_checks++;
        if (dout1 !== 32'h1111_1111) begin n_fail++; $display("FAIL collision_port1_old: got %h expected %h", dout1, 32'h1111_1111); end
        n_checks++;
        if (dout2 !== 32'h1111_1111) begin n_fail++; $display("FAIL collision_port2_old: got %h expected %h", dout2, 32'h1111_1111); end
        model_store(32'h300, 32'h2222_2222, 2'd2);
        do_fetch(32'h300, d);
        n_checks++;
        if (d !== 32'h2222_2222) begin n_fail++; $display("FAIL collision_write_landed: got %h expected %h", d, 32'h2222_2222); end
    endtask

    task automatic test_random();
        logic [31:0] d, a, w, exp_v;
        logic [1:0]  sz;
        logic        sg;
        int          op;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            do_store(32'h1000 + 4 * i, w, 2'd2);
            model_store(32'h1000 + 4 * i, w, 2'd2);
        end
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 2);
            sz = 2'($urandom_range(0, 2));
            sg = 1'($urandom_range(0, 1));
            a  = 32'h1000 + 4 * $urandom_range(0, 15);
            if (sz == 2'd0)      a = a + $urandom_range(0, 3);
            else if (sz == 2'd1) a = a + 2 * $urandom_range(0, 1);
            if (op == 0) begin
                w = $urandom;
                do_store(a, w, sz);
                model_store(a, w, sz);
            end else if (op == 1) begin
                exp_v = model_load(a, sz, sg);
                do_load(a, sz, sg, d);
                n_checks++;
                if (d !== exp_v) begin n_fail++; $display("FAIL rand_load_%0d addr=%h size=%0d sign=%b: got %h expected %h", i, a, sz, sg, d, exp_v); end
                @(negedge clk);
                n_checks++;
                if (dout2 !== exp_v) begin n_fail++; $display("FAIL rand_hold_%0d: got %h expected %h", i, dout2, exp_v); end
            end else begin
                exp_v = model_word(a);
                do_fetch({a[31:2], 2'b00}, d);
                n_checks++;
                if (d !== exp_v) begin n_fail++; $display("FAIL rand_fetch_%0d addr=%h: got %h expected %h", i, a, d, exp_v); end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        addr1 = '0; addr2 = '0; din2 = '0; size = 2'd2; sign = 1'b0; io_in = '0;
        clear_inputs();
        test_reset();
        test_word_write_fetch();
        test_subword_loads();
        test_subword_stores();
        test_io();
        test_errors();
        test_reset_midrun();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
